gray_conv_arbiter: RTL
======================

# gray_conv_arbiter

Shares one Gray-to-binary conversion datapath between N_REQ requesters. Requesters present Gray codes under a valid/ready handshake. A round-robin arbiter grants one requester per cycle. The converted binary value and the winning requester's index leave through a single registered output stage with its own valid/ready handshake. The block sits between Gray-coded sources (position encoders, CDC pointer samplers) and the binary consumers downstream.

## Interface
- N_REQ, 4, number of requesters; must be 2 or more.
- WIDTH, 4, Gray/binary word width; must be 2 or more.
- IDW, $clog2(N_REQ), width of the requester index. This is a derived localparam.

- clk  in  1  sole clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  bit i is high when requester i has a word.
- req_gray  in  N_REQ*WIDTH  Gray word for requester i at bits [i*WIDTH +: WIDTH].
- req_ready  out  N_REQ  one-hot or zero; bit i high means requester i's word is taken this cycle.
- out_valid  out  1  the output register holds a converted word.
- out_ready  in  1  the consumer accepts the output word.
- out_binary  out  WIDTH  converted binary word.
- out_id  out  IDW  index of the requester that produced out_binary.
- busy  out  1  out_valid OR any req_valid bit is high.

## Operation
- Conversion rule: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] XOR g[i] for i from WIDTH-2 down to 0.
- Output stage FSM has two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- can_accept = (state==EMPTY) OR out_ready.
- Arbitration:
  - Round robin; the search starts at index (last_grant+1) mod N_REQ and moves upward with wrap-around.
  - The first requester found with req_valid high wins.
- Grant conditions:
  - A grant occurs only when can_accept=1 and at least one req_valid bit is high.
  - On a grant, req_ready[winner]=1 and all other bits are 0.
  - With no grant, req_ready is all-zero.
- Transfers:
  - A requester transfer happens when req_valid[i] AND req_ready[i].
  - An output transfer happens when out_valid AND out_ready.
- State transitions:
  - EMPTY with a grant goes to FULL and loads out_binary and out_id.
  - EMPTY with no grant stays EMPTY.
  - FULL with out_ready=1 and a grant stays FULL and reloads the register in the same cycle, so a back-to-back stream moves one word per clock.
  - FULL with out_ready=1 and no grant goes to EMPTY.
  - FULL with out_ready=0 holds. out_binary and out_id stay stable and req_ready is all-zero.
- last_grant updates only on a grant; it takes the winner's index.
- req_ready depends combinationally on req_valid and out_ready. out_valid, out_binary and out_id are registered.
- Requesters must hold req_gray stable while req_valid is high and not yet accepted. The block does not check this.

## Timing
- Latency: a word accepted at edge k appears on out_* immediately after edge k, so it is visible in cycle k+1.
- Throughput: one word per clock while out_ready=1.
- Reset values (synchronous; take effect on the first edge with rst=1):
  - state=EMPTY, out_valid=0, out_binary=0, out_id=0.
  - last_grant=N_REQ-1, so index 0 has first priority after reset.
  - req_ready=0 while rst is high.
- Reset mid-operation:
  - A word held in the output register is discarded and no output transfer is reported.
  - Any handshake in that cycle is void.
- Fairness: under continuous requests from all N_REQ requesters with out_ready=1, each requester is granted exactly once in every N_REQ consecutive grants.
- Simultaneous events: a new request arriving in the same cycle as a grant does not change that grant. The arbitration decision uses only current-cycle inputs and last_grant.

## Structure
- Package gray_conv_pkg holds:
  - the two-state enum (ST_EMPTY, ST_FULL);
  - a function gray2bin(logic [WIDTH-1:0]) implementing the XOR chain, parameterised through a localparam default of 4.
- Sub-module rr_arbiter (N_REQ): inputs req and advance, outputs one-hot grant and grant_idx, and holds last_grant internally. It is reusable elsewhere in the codebase.
- The converter itself is combinational and is instantiated once in the top level, on the muxed winning word.

## Test plan
- Reset, then requester 0 sends gray 4'b1101 with out_ready=1 → next cycle out_valid=1, out_binary=4'b1001, out_id=0.
- All four requesters valid with gray 1000, 0011, 1010, 1111 and out_ready held high → grants in order 0,1,2,3, one per cycle; outputs 1111, 0010, 1100, 1010.
- Output stalled: out_ready=0 for 3 cycles with FULL and requests pending → req_ready=0, out_binary and out_id stable. Release ready → transfer plus reload in the same cycle.
- Requesters 1 and 3 valid continuously, after last_grant=1 → next grant 3, then 1, then 3 (alternating, no starvation).
- rst asserted while FULL with out_binary=4'b0111 → next cycle out_valid=0, out_binary=0; first post-reset grant goes to the lowest valid index.
- Sweep all 16 4-bit Gray codes through requester 2 → every out_binary matches the reference conversion, including 0000→0000 and 1000→1111.

Source files
------------

// File: rtl/gray_conv_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : gray_conv_pkg                                              |
// | Shared types and the Gray-to-binary helper for gray_conv_arbiter.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package gray_conv_pkg;

  // Default word width for the helper conversion function.
  localparam int GRAY_W = 4;

  // Output register occupancy.
  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // XOR chain from the MSB down: each binary bit is the running parity of
  // all Gray bits at or above it.
  function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
    logic [GRAY_W-1:0] b;
    b[GRAY_W-1] = g[GRAY_W-1];
    for (int i = GRAY_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rr_arbiter                                                 |
// | Round-robin arbiter. The search begins one past the last granted     |
// | index and wraps; last_grant moves only when the caller advances.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   grant_idx
);

  logic [IDW-1:0] last_grant_q;

  // Priority search starting at (last_grant + 1) mod N_REQ, moving upward.
  always_comb begin
    logic           found;
    logic [IDW:0]   sum;
    logic [IDW-1:0] cand;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      // Sum stays below 2*N_REQ, so one conditional subtract gives the modulo.
      sum = {1'b0, last_grant_q} + (IDW+1)'(off);
      if (sum >= (IDW+1)'(N_REQ)) begin
        sum = sum - (IDW+1)'(N_REQ);
      end
      cand = sum[IDW-1:0];
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Remember the winner; reset makes index 0 the first to be searched.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= IDW'(N_REQ - 1);
    end else if (advance) begin
      last_grant_q <= grant_idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gray_conv_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : gray_conv_arbiter                                          |
// | N requesters share one Gray-to-binary converter through a round-     |
// | robin arbiter; results leave via a single registered output stage.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module gray_conv_arbiter
  import gray_conv_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 4,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_gray,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_binary,
  output logic [IDW-1:0]         out_id,
  output logic                   busy
);

  out_state_e       state_q, state_d;
  logic [WIDTH-1:0] out_binary_q;
  logic [IDW-1:0]   out_id_q;

  logic [N_REQ-1:0] w_grant;
  logic [IDW-1:0]   w_grant_idx;
  logic             w_can_accept;
  logic             w_do_grant;
  logic [WIDTH-1:0] w_word;
  logic [WIDTH-1:0] w_bin;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (w_do_grant),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  // One-hot grant drives an AND-OR mux onto the single converter input.
  always_comb begin
    w_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_word = w_word | req_gray[i*WIDTH +: WIDTH];
      end
    end
  end

  generate
    if (WIDTH == GRAY_W) begin : g_conv_pkg
      assign w_bin = gray2bin(w_word);
    end else begin : g_conv_chain
      // Same XOR chain for widths other than the package default.
      always_comb begin
        w_bin = '0;
        w_bin[WIDTH-1] = w_word[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
          w_bin[i] = w_bin[i+1] ^ w_word[i];
        end
      end
    end
  endgenerate

  // Grant decision, requester handshake and output-stage next state.
  always_comb begin
    state_d      = state_q;
    req_ready    = '0;
    w_can_accept = (state_q == ST_EMPTY) || out_ready;
    // Reset voids any handshake in the cycle it is asserted.
    w_do_grant   = w_can_accept && (|req_valid) && !rst;
    if (w_do_grant) begin
      req_ready = w_grant;
    end
    case (state_q)
      ST_EMPTY: begin
        if (w_do_grant) state_d = ST_FULL;
      end
      ST_FULL: begin
        if (out_ready && !w_do_grant) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Output register: reload on every grant, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      out_binary_q <= '0;
      out_id_q     <= '0;
    end else begin
      state_q <= state_d;
      if (w_do_grant) begin
        out_binary_q <= w_bin;
        out_id_q     <= w_grant_idx;
      end
    end
  end

  assign out_valid  = (state_q == ST_FULL);
  assign out_binary = out_binary_q;
  assign out_id     = out_id_q;
  assign busy       = out_valid || (|req_valid);

endmodule
`default_nettype wire
